// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the load/store unit: RV32I funct3
//               width codes, FSM state encoding and access-size helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_WR2  = 3'd2,
    ST_RD   = 3'd3,
    ST_RDW  = 3'd4,
    ST_RD2  = 3'd5,
    ST_RDW2 = 3'd6,
    ST_RESP = 3'd7
  } lsu_state_t;

  // Byte-lane mask of an access, before shifting to its offset.
  // size is funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      2'b10:   size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

  // Offset of the last byte touched, relative to the first (size - 1).
  function automatic logic [1:0] size_last(input logic [1:0] size);
    case (size)
      2'b00:   size_last = 2'd0;
      2'b01:   size_last = 2'd1;
      default: size_last = 2'd3;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Purely combinational lane alignment for the load/store unit.
//               Store side: byte enables and write data shifted to the byte
//               offset, as a low/high word pair (high half used only when an
//               access crosses into the next word).
//               Load side: merges the low word with the bottom three bytes
//               of the following word, extracts the addressed lanes and
//               sign/zero-extends them.
// Ports       : funct3    in  3   RV32I width code
//               offset    in  2   byte offset within the word
//               wdata     in  32  right-aligned store data
//               lo_word   in  32  first word read
//               hi_word   in  24  low three bytes of the following word
//               be_pair   out 8   {high word enables, low word enables}
//               din_pair  out 64  {high word data, low word data}
//               rdata     out 32  extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] lo_word,
  input  logic [23:0] hi_word,
  output logic [7:0]  be_pair,
  output logic [63:0] din_pair,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  assign be_pair  = {4'b0000, size_mask(funct3[1:0])} << offset;
  assign din_pair = {32'h0, wdata} << {offset, 3'b000};

  // A word at offset 3 reaches at most byte 2 of the next word, so the
  // top byte of the high word is never needed.
  always_comb begin
    shifted = lo_word;
    case (offset)
      2'd0: shifted = lo_word;
      2'd1: shifted = {hi_word[7:0],  lo_word[31:8]};
      2'd2: shifted = {hi_word[15:0], lo_word[31:16]};
      2'd3: shifted = {hi_word[23:0], lo_word[31:24]};
      default: shifted = lo_word;
    endcase
  end

  always_comb begin
    rdata = shifted;
    case (funct3)
      F3_B:    rdata = {{24{shifted[7]}},  shifted[7:0]};
      F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   rdata = {24'h0, shifted[7:0]};
      F3_HU:   rdata = {16'h0, shifted[15:0]};
      default: rdata = shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Initiator side of the data-memory port. Accepts one load or
//               store at a time, drives a registered-read, byte-enable-write
//               memory and returns the extended load result or an error.
//               Build option LSU_MISALIGN_SPLIT_EN: when defined, misaligned
//               accesses are performed (split into two word accesses when
//               they cross a word); when undefined they return an error.
// Ports       : clk, rst            clock, synchronous active-high reset
//               req_valid/req_ready request handshake
//               req_we, req_funct3  store flag, RV32I width code
//               req_addr, req_wdata byte address, right-aligned store data
//               resp_valid          one-cycle completion pulse
//               resp_rdata          load result (0 for stores/errors)
//               resp_err            illegal / misaligned / out-of-range
//               mem_addr, mem_din   word address and lane-shifted data
//               mem_we              byte-lane write enables
//               mem_dout            registered memory read data
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_dout
);

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

  lsu_state_t  state, state_next;

  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_err;
  logic        r_split;
  logic [31:0] r_lo_buf;
  logic [23:0] r_hi_buf;

  logic        w_accept;
  logic        w_f3_legal;
  logic [32:0] w_last_byte;
  logic        w_range_err;
  logic        w_misalign_err;
  logic        w_split;
  logic        w_err;
  logic [31:0] w_word_addr;
  logic [7:0]  w_be_pair;
  logic [63:0] w_din_pair;
  logic [31:0] w_rdata;

  assign req_ready = (state == ST_IDLE);
  assign w_accept  = req_valid && req_ready;

  // ---- request decode (on the live request, used only at accept) ----------
  assign w_f3_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) ||
                      (req_funct3 == F3_W) ||
                      (!req_we && ((req_funct3 == F3_BU) || (req_funct3 == F3_HU)));

  // 33-bit sum so an access near 0xFFFF_FFFF cannot wrap back into range.
  assign w_last_byte = {1'b0, req_addr} + {31'h0, size_last(req_funct3[1:0])};
  assign w_range_err = (w_last_byte >= ADDR_LIMIT);

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [2:0] w_end_lane;
  // Lane of the last byte; bit 2 set means it spills into the next word.
  assign w_end_lane     = {1'b0, req_addr[1:0]} + {1'b0, size_last(req_funct3[1:0])};
  assign w_split        = w_end_lane[2];
  assign w_misalign_err = 1'b0;
`else
  assign w_split        = 1'b0;
  assign w_misalign_err = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`endif

  assign w_err = !w_f3_legal || w_range_err || w_misalign_err;

  // ---- lane alignment ------------------------------------------------------
  lsu_align u_align (
    .funct3   (r_funct3),
    .offset   (r_addr[1:0]),
    .wdata    (r_wdata),
    .lo_word  (r_lo_buf),
    .hi_word  (r_hi_buf),
    .be_pair  (w_be_pair),
    .din_pair (w_din_pair),
    .rdata    (w_rdata)
  );

  // ---- state, request latch and read buffers -------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_err    <= 1'b0;
      r_split  <= 1'b0;
      r_lo_buf <= 32'h0;
      r_hi_buf <= 24'h0;
    end else begin
      state <= state_next;
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_err    <= w_err;
        r_split  <= w_split;
      end
      if (state == ST_RDW) begin
        r_lo_buf <= mem_dout;
      end
      if (state == ST_RDW2) begin
        r_hi_buf <= mem_dout[23:0];
      end
    end
  end

  assign w_word_addr = {r_addr[31:2], 2'b00};

  // ---- next state and outputs ---------------------------------------------
  always_comb begin
    state_next = state;
    mem_addr   = 32'h0;
    mem_din    = 32'h0;
    mem_we     = 4'b0000;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;

    case (state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_err)       state_next = ST_RESP;
          else if (req_we) state_next = ST_WR;
          else             state_next = ST_RD;
        end
      end
      ST_WR: begin
        mem_addr   = w_word_addr;
        mem_din    = w_din_pair[31:0];
        mem_we     = w_be_pair[3:0];
        state_next = r_split ? ST_WR2 : ST_RESP;
      end
      ST_WR2: begin
        mem_addr   = w_word_addr + 32'd4;
        mem_din    = w_din_pair[63:32];
        mem_we     = w_be_pair[7:4];
        state_next = ST_RESP;
      end
      ST_RD: begin
        mem_addr   = w_word_addr;
        state_next = ST_RDW;
      end
      ST_RDW: begin
        mem_addr   = w_word_addr;
        state_next = r_split ? ST_RD2 : ST_RESP;
      end
      ST_RD2: begin
        mem_addr   = w_word_addr + 32'd4;
        state_next = ST_RDW2;
      end
      ST_RDW2: begin
        mem_addr   = w_word_addr + 32'd4;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        if (!r_err && !r_we) resp_rdata = w_rdata;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Suppress any write on the reset edge so an aborted store leaves
    // memory untouched.
    if (rst) mem_we = 4'b0000;
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit with a
//               registered-read, byte-enable-write memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_we;
  logic [31:0] mem_dout;

  int checks   = 0;
  int failures = 0;

  // results of the last run_req
  int          lat;
  logic [31:0] rd;
  logic        er;
  int          we_cycles;
  logic [3:0]  we_mask;
  logic [31:0] din_seen;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_we     (mem_we),
    .mem_dout   (mem_dout)
  );

  // memory model: registered read (read-old), byte-enable write
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_din[8*b +: 8];
    end
    mem_dout <= mem[mem_addr[11:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request, then watch up to 8 cycles for the response.
  // lat stays 0 if no response arrives.
  task run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
               input logic [31:0] wd);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    lat = 0; rd = 32'hx; er = 1'bx; we_cycles = 0; we_mask = 4'b0; din_seen = 32'h0;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'h5A5A_5A5A;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_we != 4'b0) begin
        we_cycles++;
        we_mask  = mem_we;
        din_seen = mem_din;
      end
      if (resp_valid) begin
        lat = c;
        rd  = resp_rdata;
        er  = resp_err;
        break;
      end
    end
  endtask

  int seen_resp;

  initial begin
    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_mem_we",  {28'h0, mem_we}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready",   {31'h0, req_ready}, 32'h1);
    check("rst_valid",   {31'h0, resp_valid}, 32'h0);
    check("rst_rdata",   resp_rdata, 32'h0);
    check("rst_err",     {31'h0, resp_err}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);

    // ---- 1: SW / LW aligned ----
    run_req(1'b1, 3'b010, 32'h10, 32'h1234_5678);
    check("sw_lat",  32'(lat), 32'd2);
    check("sw_err",  {31'h0, er}, 32'h0);
    check("sw_rdata", rd, 32'h0);
    check("sw_we_cycles", 32'(we_cycles), 32'd1);
    check("sw_we_mask", {28'h0, we_mask}, 32'hF);
    check("sw_mem", mem[4], 32'h1234_5678);
    run_req(1'b0, 3'b010, 32'h10, 32'h0);
    check("lw_lat",  32'(lat), 32'd3);
    check("lw_rdata", rd, 32'h1234_5678);
    check("lw_err",  {31'h0, er}, 32'h0);

    // ---- 2: SB / LB / LBU at lane 3 ----
    run_req(1'b1, 3'b000, 32'h13, 32'h0000_00AB);
    check("sb_we_mask", {28'h0, we_mask}, 32'h8);
    check("sb_din_b3", {24'h0, din_seen[31:24]}, 32'hAB);
    check("sb_mem", mem[4], 32'hAB34_5678);
    run_req(1'b0, 3'b000, 32'h13, 32'h0);
    check("lb_rdata", rd, 32'hFFFF_FFAB);
    run_req(1'b0, 3'b100, 32'h13, 32'h0);
    check("lbu_rdata", rd, 32'h0000_00AB);
    check("lbu_we_cycles", 32'(we_cycles), 32'd0);

    // ---- 3: halfword sign/zero extension ----
    run_req(1'b1, 3'b010, 32'h10, 32'h8001_7FFF);
    run_req(1'b0, 3'b001, 32'h12, 32'h0);
    check("lh_hi_rdata", rd, 32'hFFFF_8001);
    run_req(1'b0, 3'b101, 32'h10, 32'h0);
    check("lhu_lo_rdata", rd, 32'h0000_7FFF);
    run_req(1'b0, 3'b001, 32'h10, 32'h0);
    check("lh_lo_rdata", rd, 32'h0000_7FFF);

    // ---- 4: misaligned word crossing a word boundary ----
    run_req(1'b1, 3'b010, 32'h10, 32'h4433_2211);
    run_req(1'b1, 3'b010, 32'h14, 32'h8877_6655);
    run_req(1'b0, 3'b010, 32'h11, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
    check("lw_split_lat", 32'(lat), 32'd5);
    check("lw_split_err", {31'h0, er}, 32'h0);
    check("lw_split_rdata", rd, 32'h5544_3322);
`else
    check("lw_mis_lat", 32'(lat), 32'd1);
    check("lw_mis_err", {31'h0, er}, 32'h1);
    check("lw_mis_rdata", rd, 32'h0);
`endif
    check("lw_mis_we_cycles", 32'(we_cycles), 32'd0);

    // ---- 5: range and illegal funct3 ----
    run_req(1'b0, 3'b010, 32'h1000, 32'h0);
    check("lw_oor_err", {31'h0, er}, 32'h1);
    check("lw_oor_lat", 32'(lat), 32'd1);
    run_req(1'b0, 3'b011, 32'h10, 32'h0);
    check("ld_f3_011_err", {31'h0, er}, 32'h1);
    check("ld_f3_011_rdata", rd, 32'h0);
    run_req(1'b1, 3'b100, 32'h10, 32'h0000_00FF);
    check("sb_f3_100_err", {31'h0, er}, 32'h1);
    check("sb_f3_100_we", 32'(we_cycles), 32'd0);
    check("sb_f3_100_mem", mem[4], 32'h4433_2211);
    run_req(1'b1, 3'b010, 32'hFFC, 32'hCAFE_F00D);
    check("sw_last_err", {31'h0, er}, 32'h0);
    run_req(1'b0, 3'b010, 32'hFFC, 32'h0);
    check("lw_last_rdata", rd, 32'hCAFE_F00D);
    run_req(1'b0, 3'b000, 32'hFFF, 32'h0);
    check("lb_last_rdata", rd, 32'hFFFF_FFCA);
    run_req(1'b0, 3'b001, 32'hFFF, 32'h0);
    check("lh_fff_err", {31'h0, er}, 32'h1);

    // ---- 6: reset during the write cycle of a store ----
    run_req(1'b1, 3'b010, 32'h20, 32'h0BAD_F00D);
    check("sw20_mem", mem[8], 32'h0BAD_F00D);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h20;
    req_wdata  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("abort_we_before_rst", {28'h0, mem_we}, 32'hF);
    rst = 1'b1;
    #1;
    check("abort_we_in_rst", {28'h0, mem_we}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_ready", {31'h0, req_ready}, 32'h1);
    seen_resp = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid) seen_resp++;
    end
    check("abort_no_resp", 32'(seen_resp), 32'd0);
    check("abort_mem", mem[8], 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
